// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider.
// Configuration arrives over a valid/ready handshake and only takes effect at
// a divided-period boundary, so clk_out never produces a runt pulse.
// Odd factors get a ~50% duty cycle by ORing in a negedge-delayed copy of the
// posedge-generated clock.
module clk_div_ctrl #(
    parameter int MAX_FACTOR = 16,
    parameter int W          = $clog2(MAX_FACTOR + 1)
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_factor,
    input  logic         cfg_enable,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         tick,
    output logic [W-1:0] active_factor,
    output logic         running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] MIN_FAC = W'(2);
    localparam logic [W-1:0] MAX_FAC = W'(MAX_FACTOR);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   fac_q, fac_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   pend_fac_q, pend_fac_d;
    logic           tick_q, tick_d;
    logic           err_q, err_d;
    logic           running_q, running_d;
    logic           clk_n_q, clk_n_d;

    logic           accept;
    logic           legal;
    logic           wrap;
    logic           clk_p;

    assign accept = cfg_valid && cfg_ready;
    assign legal  = (cfg_factor >= MIN_FAC) && (cfg_factor <= MAX_FAC);
    assign wrap   = (cnt_q == fac_q - ONE);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: enable leaves IDLE, disable drains the current period
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && cfg_enable && legal) state_d = RUN;
            RUN:     if (accept && !cfg_enable)         state_d = DRAIN;
            DRAIN:   if (wrap)                          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one pending request at a time, nothing accepted while draining
    always_comb begin
        cfg_ready = 1'b0;
        case (state_q)
            IDLE:    cfg_ready = 1'b1;
            RUN:     cfg_ready = !pend_q;
            default: cfg_ready = 1'b0;
        endcase
    end

    // Datapath next values: period counter, factor load, pending request, pulses
    always_comb begin
        cnt_d      = cnt_q;
        fac_d      = fac_q;
        pend_d     = pend_q;
        pend_fac_d = pend_fac_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && cfg_enable) begin
                    if (legal) begin
                        cnt_d = '0;
                        fac_d = cfg_factor;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + ONE;
                // A pending factor swaps in exactly at the wrap; the request
                // accepted on this same edge (if any) waits for the next one.
                if (wrap && pend_q) begin
                    fac_d  = pend_fac_q;
                    pend_d = 1'b0;
                end
                if (accept && cfg_enable) begin
                    if (legal) begin
                        pend_d     = 1'b1;
                        pend_fac_d = cfg_factor;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (wrap) begin
                    cnt_d = '0;
                    fac_d = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                cnt_d = '0;
                fac_d = '0;
            end
        endcase
        running_d = (state_d != IDLE);
        tick_d    = running_d && (cnt_d == '0);
    end

    // Datapath registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q      <= '0;
            fac_q      <= '0;
            pend_q     <= 1'b0;
            pend_fac_q <= '0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            fac_q      <= fac_d;
            pend_q     <= pend_d;
            pend_fac_q <= pend_fac_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            running_q  <= running_d;
        end
    end

    // High half of the period; cnt==F-1 is always in the low half, so factor
    // switches land while both clk_p and clk_n are low.
    assign clk_p   = running_q && (cnt_q < (fac_q >> 1));
    assign clk_n_d = rst ? 1'b0 : clk_p;

    // Half-cycle extension flop for odd factors
    always_ff @(negedge clk_in) begin
        clk_n_q <= clk_n_d;
    end

    assign clk_out       = clk_p | (fac_q[0] & clk_n_q);
    assign tick          = tick_q;
    assign cfg_err       = err_q;
    assign active_factor = fac_q;
    assign running       = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for the cycle-level
// behaviour, plus hand sequences for odd-factor half cycles and mid-period reset.
module tb_clk_div_ctrl;

    localparam int MAX_FACTOR = 16;
    localparam int W          = $clog2(MAX_FACTOR + 1);

    logic         clk_in = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_factor;
    logic         cfg_enable;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] active_factor;
    logic         running;

    int pass_cnt = 0;
    int total    = 0;

    clk_div_ctrl #(.MAX_FACTOR(MAX_FACTOR), .W(W)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_factor    (cfg_factor),
        .cfg_enable    (cfg_enable),
        .cfg_err       (cfg_err),
        .clk_out       (clk_out),
        .tick          (tick),
        .active_factor (active_factor),
        .running       (running)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         v;
        logic [W-1:0] f;
        logic         en;
        logic         rdy;
        logic         clk;
        logic         tk;
        logic         err;
        logic [W-1:0] af;
        logic         run;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic v, input int f, input logic en,
                                input logic rdy, input logic clk, input logic tk,
                                input logic err, input int af, input logic run);
        vec_t r;
        r.v = v; r.f = W'(f); r.en = en;
        r.rdy = rdy; r.clk = clk; r.tk = tk; r.err = err; r.af = W'(af); r.run = run;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    endtask

    task automatic chk_all(input int idx, input logic rdy, input logic clk, input logic tk,
                           input logic err, input int af, input logic run);
        chk("cfg_ready", idx, int'(cfg_ready), int'(rdy));
        chk("clk_out", idx, int'(clk_out), int'(clk));
        chk("tick", idx, int'(tick), int'(tk));
        chk("cfg_err", idx, int'(cfg_err), int'(err));
        chk("active_factor", idx, int'(active_factor), af);
        chk("running", idx, int'(running), int'(run));
    endtask

    task automatic drive(input logic v, input int f, input logic en);
        cfg_valid  = v;
        cfg_factor = W'(f);
        cfg_enable = en;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic pos5[5];
        logic neg5[5];
        pos5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        neg5 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // inputs applied before an edge, expected outputs after that edge
        vq.push_back(mk(1, 4, 1,  1, 1, 1, 0, 4, 1));   // enable F=4, cnt0
        vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 4, 1));   // cnt1
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 4, 1));   // cnt2
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 4, 1));   // cnt3
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 4, 1));   // cnt0
        vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 4, 1));   // cnt1
        vq.push_back(mk(1, 6, 1,  0, 0, 0, 0, 4, 1));   // F=6 pending, cnt2
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 4, 1));   // cnt3
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 6, 1));   // wrap loads 6
        vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 1, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 6, 1));   // cnt0
        vq.push_back(mk(1, 1, 1,  1, 1, 0, 1, 6, 1));   // factor 1 -> err
        vq.push_back(mk(1, 17, 1, 1, 1, 0, 1, 6, 1));   // factor 17 -> err
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));   // cnt3
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 6, 1));   // cnt5
        vq.push_back(mk(1, 2, 1,  0, 1, 1, 0, 6, 1));   // accepted at wrap -> next wrap
        vq.push_back(mk(0, 0, 0,  0, 1, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  0, 1, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 6, 1));
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 2, 1));   // F=2 now
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 2, 1));
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 2, 1));
        vq.push_back(mk(1, 8, 1,  0, 0, 0, 0, 2, 1));   // F=8 pending
        vq.push_back(mk(0, 0, 0,  1, 1, 1, 0, 8, 1));   // cnt0 F=8
        vq.push_back(mk(1, 0, 0,  0, 1, 0, 0, 8, 1));   // disable -> DRAIN, no err
        vq.push_back(mk(0, 0, 0,  0, 1, 0, 0, 8, 1));
        vq.push_back(mk(0, 0, 0,  0, 1, 0, 0, 8, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 8, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 8, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 8, 1));
        vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 8, 1));   // cnt7
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0));   // IDLE
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0));   // no further tick
        vq.push_back(mk(1, 0, 0,  1, 0, 0, 0, 0, 0));   // disable in IDLE: no-op
        vq.push_back(mk(1, 0, 1,  1, 0, 0, 1, 0, 0));   // illegal enable in IDLE
        vq.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 0));

        rst = 1'b1;
        drive(0, 0, 0);
        repeat (3) step();
        rst = 1'b0;
        chk_all(-1, 1, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].v, int'(vq[i].f), vq[i].en);
            step();
            chk_all(i, vq[i].rdy, vq[i].clk, vq[i].tk, vq[i].err, int'(vq[i].af), vq[i].run);
        end

        // Odd factor: 2.5 cycles high, 2.5 low, checked on both edges
        drive(1, 5, 1);
        step();
        drive(0, 0, 0);
        chk("af5", 0, int'(active_factor), 5);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                chk("f5_pos", p * 5 + c, int'(clk_out), int'(pos5[c]));
                chk("f5_tick", p * 5 + c, int'(tick), (c == 0) ? 1 : 0);
                @(negedge clk_in);
                #1;
                chk("f5_neg", p * 5 + c, int'(clk_out), int'(neg5[c]));
                step();
            end
        end

        // Reset at cnt=2 with F=6
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, 6, 1);
        step();
        drive(0, 0, 0);
        step();
        step();
        chk("f6_cnt2_clk", 0, int'(clk_out), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all(100, 1, 0, 0, 0, 0, 0);
        @(negedge clk_in);
        #1;
        chk("rst_neg_clk", 0, int'(clk_out), 0);
        step();
        drive(1, 2, 1);
        step();
        drive(0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            chk("f2_clk", c, int'(clk_out), (c % 2 == 0) ? 1 : 0);
            chk("f2_tick", c, int'(tick), (c % 2 == 0) ? 1 : 0);
            chk("f2_af", c, int'(active_factor), 2);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock divider controller.
- Accepts divide-factor and enable configuration through a valid/ready handshake.
- Applies every change only at a divided-period boundary, so clk_out never glitches or produces a runt pulse.
- Produces a ~50% duty divided clock (odd factors via a negedge half-cycle extension), a period-start tick for downstream logic in the clk_in domain, and status outputs.

Parameters:
- MAX_FACTOR, 16, largest legal divide factor.
- W, $clog2(MAX_FACTOR+1), width of factor fields and the period counter.

Ports:
- clk_in  input  1  source clock; all logic posedge except the single half-cycle flop.
- rst  input  1  reset, synchronous, active-high.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  controller can accept a configuration this cycle.
- cfg_factor  input  W  requested divide factor; legal range 2..MAX_FACTOR.
- cfg_enable  input  1  1 = run divider, 0 = stop divider.
- cfg_err  output  1  one-cycle pulse: an accepted request had an illegal factor.
- clk_out  output  1  divided clock.
- tick  output  1  one-cycle pulse in the first clk_in cycle of each divided period.
- active_factor  output  W  factor currently in effect; 0 when idle.
- running  output  1  high in RUN and DRAIN.

Behaviour:
Reset:
- State IDLE, cnt=0, no pending request.
- clk_out=0, tick=0, cfg_err=0, active_factor=0, running=0, cfg_ready=1.
- Reset asserted mid-period forces these values on the next posedge, dropping any pending request. The negedge flop clears on the following negedge.

Handshake:
- A transfer occurs on a posedge with cfg_valid && cfg_ready.
- cfg_ready=1 in IDLE and in RUN with no pending request. It is 0 while a request is pending, and 0 in DRAIN.

Illegal factor:
- An illegal factor (<2 or >MAX_FACTOR) with cfg_enable=1 is consumed.
- cfg_err pulses the following cycle, and state and factor are unchanged.
- With cfg_enable=0 the factor is ignored and never flagged.

IDLE:
- A legal enable request moves to RUN next cycle with cnt=0 and active_factor=cfg_factor.
- A disable request in IDLE is a no-op.

RUN:
- cnt counts 0..active_factor-1, then wraps to 0.
- tick=1 exactly when cnt==0.
- An accepted request becomes pending and is applied at the wrap:
  - Legal enable: the new factor is loaded together with cnt<=0, so the next period uses the new factor and tick fires normally.
  - Disable: move to DRAIN immediately, then to IDLE at the wrap.
- Consequently a change takes effect 1..F cycles after acceptance, where F is the old factor.

DRAIN:
- Continues the current period unchanged.
- At cnt==active_factor-1, moves to IDLE; clk_out is low from then on.

Clock generation:
- clk_p = running && (cnt < active_factor/2), integer division.
- clk_n is clk_p registered on negedge clk_in.
- Even factor: clk_out=clk_p. Odd factor: clk_out=clk_p|clk_n.
- Result: high for F/2 cycles (even) or F/2+0.5 cycles (odd); e.g. F=5 gives 2.5 high, 2.5 low.
- Selecting odd/even from active_factor must not glitch at a factor switch. The switch happens when clk_p=0 and clk_n=0, because cnt==F-1 >= F/2 for every F>=2.

Simultaneous events:
- cfg_valid at the same posedge as a wrap with nothing pending: the request is accepted and becomes pending. It is applied at the next wrap, not the current one.

Registered outputs:
- tick, cfg_err, active_factor and running are registered.
- clk_out is combinational from the two flops only.

Test Plan:
- Reset, then cfg factor=4 enable=1 -> running=1 next cycle; clk_out pattern 1100 repeating; tick every 4 cycles, aligned with the clk_out rising edge.
- factor=5 -> clk_out high 2.5 clk_in cycles and low 2.5 per period; tick period 5; no sub-cycle glitch checked at the negedge.
- While running F=4, request F=6 at cnt=1 -> cfg_ready=0 until the wrap; period completes at 4 cycles; next period is 6 cycles (111000); active_factor=6.
- Request factor=1 and factor=MAX_FACTOR+1 with enable=1 -> cfg_err pulses one cycle each; active_factor and period unchanged.
- Disable at cnt=0 with F=8 -> state DRAIN, period completes (11110000); running=0 and clk_out=0 afterwards; no further tick.
- Assert rst at cnt=2 with F=6 -> all outputs reach reset values next cycle, cfg_ready=1; a new enable F=2 then gives 10 repeating.
